// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter using shift-and-add-3,
// one input bit per clock. start/busy/done handshake, overflow saturation and
// a leading-zero significance mask registered together with the result.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     digit_en
);

    localparam int BCD_W = 4 * DIGITS;
    // Wide enough to hold both the input and 10**DIGITS (< 2**(4*DIGITS)).
    localparam int CMP_W = ((BIN_W > BCD_W) ? BIN_W : BCD_W) + 1;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // 10**n evaluated at elaboration time in CMP_W bits.
    function automatic logic [CMP_W-1:0] pow10(input int n);
        logic [CMP_W-1:0] p;
        p = CMP_W'(1);
        for (int i = 0; i < n; i++) begin
            p = p * CMP_W'(10);
        end
        return p;
    endfunction

    localparam logic [CMP_W-1:0] LIMIT   = pow10(DIGITS);
    localparam logic [CMP_W-1:0] MAX_BIN = {{(CMP_W-BIN_W){1'b0}}, {BIN_W{1'b1}}};
    // When every input value is representable the overflow path folds to 0.
    localparam bit               OVF_POSSIBLE = (MAX_BIN >= LIMIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    // Pre-shift correction: digits 5..9 get +3 so the following doubling
    // carries into the next digit. Values stay <= 12, so no inter-digit carry.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Saturated display value: every digit shows 9.
    function automatic logic [BCD_W-1:0] saturate_bcd();
        logic [BCD_W-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // A digit is significant if it or any higher digit is nonzero; units always shown.
    function automatic logic [DIGITS-1:0] lead_mask(input logic [BCD_W-1:0] s);
        logic [DIGITS-1:0] m;
        logic              seen;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen = seen | (s[4*i +: 4] != 4'd0);
            m[i] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   scratch;
    logic               ovf_pend;
    logic               load;
    logic               last;
    logic               ovf_cap;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   step_scratch;
    logic [BIN_W-1:0]   step_shreg;

    assign ovf_cap = OVF_POSSIBLE && ({{(CMP_W-BIN_W){1'b0}}, bin} >= LIMIT);
    assign busy    = (state == SHIFT);

    // State register; reset abandons any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus accept/finish strobes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST_CNT) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Iteration counter: cleared on accept, advances once per shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (state == SHIFT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // One shift-and-add-3 iteration; bits carried beyond the top digit drop off.
    always_comb begin
        adj          = add3_digits(scratch);
        step_scratch = {adj[BCD_W-2:0], shreg[BIN_W-1]};
        step_shreg   = shreg << 1;
    end

    // Working registers: capture on accept, iterate while shifting.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg    <= bin;
            scratch  <= '0;
            ovf_pend <= ovf_cap;
        end else if (state == SHIFT) begin
            shreg    <= step_shreg;
            scratch  <= step_scratch;
        end
    end

    // Result registers: updated only on the final iteration, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            digit_en <= DIGITS'(1);
        end else begin
            done <= last;
            if (last) begin
                overflow <= ovf_pend;
                if (ovf_pend) begin
                    bcd      <= saturate_bcd();
                    digit_en <= '1;
                end else begin
                    bcd      <= step_scratch;
                    digit_en <= lead_mask(step_scratch);
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: default 10-bit/4-digit instance plus a
// 3-digit instance for saturation, checked against an arithmetic reference.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start3;
    logic [9:0]  bin, bin3;
    logic        busy, done, ovf;
    logic [15:0] bcd;
    logic [3:0]  en;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic [2:0]  en3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(ovf), .digit_en(en)
    );

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .bin(bin3),
        .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3), .digit_en(en3)
    );

    // Reference: decimal digits by division; saturation when v >= 10**nd.
    function automatic void ref_conv(input int v, input int nd, output logic [15:0] b,
                                     output logic o, output logic [3:0] e);
        int lim;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        b = '0;
        e = '0;
        o = (v >= lim);
        for (int i = 0; i < nd; i++) begin
            int p;
            p = 1;
            for (int j = 0; j < i; j++) p = p * 10;
            b[4*i +: 4] = o ? 4'd9 : 4'((v / p) % 10);
            e[i] = o || (i == 0) || (v >= p);
        end
    endfunction

    // Starts one conversion on the chosen instance and waits (bounded) for done.
    // Returns at the done cycle, 1 time unit after the clock edge.
    task automatic do_conv(input bit sel, input logic [9:0] v, output int bc, output int dc,
                           output bit to, output bit held, output bit overlap);
        logic [15:0] prev;
        prev = sel ? {4'h0, bcd3} : bcd;
        if (sel) begin start3 = 1'b1; bin3 = v; end
        else     begin start  = 1'b1; bin  = v; end
        @(posedge clk); #1;
        start = 1'b0; start3 = 1'b0;
        bin = 10'($urandom); bin3 = 10'($urandom);
        bc = 0; dc = 0; to = 1'b1; held = 1'b1; overlap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic        b_, d_;
            logic [15:0] cur;
            b_  = sel ? busy3 : busy;
            d_  = sel ? done3 : done;
            cur = sel ? {4'h0, bcd3} : bcd;
            if (b_ && d_) overlap = 1'b1;
            if (b_) bc++;
            if (d_) begin dc++; to = 1'b0; break; end
            if (cur !== prev) held = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (en !== 4'b0001) begin failures++; $display("FAIL reset_en got=%b exp=0001", en); end
        checks++; if (en3 !== 3'b001) begin failures++; $display("FAIL reset_en3 got=%b exp=001", en3); end
    endtask

    task automatic test_single(input logic [9:0] v);
        int bc, dc; bit to, held, ov;
        logic [15:0] eb; logic eo; logic [3:0] ee;
        ref_conv(int'(v), 4, eb, eo, ee);
        do_conv(1'b0, v, bc, dc, to, held, ov);
        checks++; if (to) begin failures++; $display("FAIL single_timeout v=%0d no done within bound", v); end
        checks++; if (bc != 10) begin failures++; $display("FAIL single_busy_len v=%0d got=%0d exp=10", v, bc); end
        checks++; if (!held) begin failures++; $display("FAIL single_hold v=%0d bcd changed while busy", v); end
        checks++; if (ov) begin failures++; $display("FAIL single_overlap v=%0d busy and done together", v); end
        checks++; if (bcd !== eb) begin failures++; $display("FAIL single_bcd v=%0d got=%h exp=%h", v, bcd, eb); end
        checks++; if (en !== ee) begin failures++; $display("FAIL single_en v=%0d got=%b exp=%b", v, en, ee); end
        checks++; if (ovf !== eo) begin failures++; $display("FAIL single_ovf v=%0d got=%b exp=%b", v, ovf, eo); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse v=%0d done still high", v); end
        checks++; if (bcd !== eb) begin failures++; $display("FAIL single_bcd_hold v=%0d got=%h exp=%h", v, bcd, eb); end
    endtask

    task automatic test_overflow3(input logic [9:0] v);
        int bc, dc; bit to, held, ov;
        logic [15:0] eb; logic eo; logic [3:0] ee;
        ref_conv(int'(v), 3, eb, eo, ee);
        do_conv(1'b1, v, bc, dc, to, held, ov);
        checks++; if (to) begin failures++; $display("FAIL ovf3_timeout v=%0d no done", v); end
        checks++; if (bcd3 !== eb[11:0]) begin failures++; $display("FAIL ovf3_bcd v=%0d got=%h exp=%h", v, bcd3, eb[11:0]); end
        checks++; if (en3 !== ee[2:0]) begin failures++; $display("FAIL ovf3_en v=%0d got=%b exp=%b", v, en3, ee[2:0]); end
        checks++; if (ovf3 !== eo) begin failures++; $display("FAIL ovf3_flag v=%0d got=%b exp=%b", v, ovf3, eo); end
    endtask

    task automatic test_start_ignored();
        int ndone;
        logic [15:0] got;
        start = 1'b1; bin = 10'd42;
        @(posedge clk); #1;
        start = 1'b0; bin = 10'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1;                     // busy cycle 3
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; got = '0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin ndone++; got = bcd; end
            @(posedge clk); #1;
        end
        checks++; if (ndone != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        checks++; if (got !== 16'h0042) begin failures++; $display("FAIL ignore_bcd got=%h exp=0042", got); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int ndone, nbusy, bc, dc; bit to, held, ov;
        start = 1'b1; bin = 10'd512;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
        checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL rstmid_bcd got=%h exp=0000", bcd); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rstmid_ovf got=%b exp=0", ovf); end
        checks++; if (en !== 4'b0001) begin failures++; $display("FAIL rstmid_en got=%b exp=0001", en); end
        @(posedge clk); #1;
        reset = 1'b0;
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) ndone++;
            if (busy) nbusy++;
            @(posedge clk); #1;
        end
        checks++; if (ndone != 0 || nbusy != 0) begin failures++; $display("FAIL rstmid_quiet done=%0d busy=%0d exp=0,0", ndone, nbusy); end
        do_conv(1'b0, 10'd512, bc, dc, to, held, ov);
        checks++; if (to || bcd !== 16'h0512) begin failures++; $display("FAIL rstmid_restart got=%h timeout=%b exp=0512", bcd, to); end
    endtask

    task automatic test_back_to_back();
        int t1, t2, n;
        logic [15:0] b1, b2;
        t1 = -1; t2 = -1; n = 0; b1 = '0; b2 = '0;
        start = 1'b1; bin = 10'd1023;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 2) bin = 10'd1;
            if (done) begin
                n++;
                if (n == 1) begin t1 = c; b1 = bcd; end
                else begin t2 = c; b2 = bcd; break; end
            end
        end
        start = 1'b0;
        checks++; if (n != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", n); end
        checks++; if (t1 != 11) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=11", t1); end
        checks++; if (t2 - t1 != 11) begin failures++; $display("FAIL b2b_interval got=%0d exp=11", t2 - t1); end
        checks++; if (b1 !== 16'h1023) begin failures++; $display("FAIL b2b_bcd1 got=%h exp=1023", b1); end
        checks++; if (b2 !== 16'h0001) begin failures++; $display("FAIL b2b_bcd2 got=%h exp=0001", b2); end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep();
        int bc, dc; bit to, held, ov;
        logic [15:0] eb; logic eo; logic [3:0] ee;
        for (int v = 0; v < 1024; v++) begin
            ref_conv(v, 4, eb, eo, ee);
            do_conv(1'b0, 10'(v), bc, dc, to, held, ov);
            checks++;
            if (to || bcd !== eb || en !== ee || ovf !== eo)
                begin failures++; $display("FAIL sweep v=%0d got bcd=%h en=%b ovf=%b to=%b exp bcd=%h en=%b ovf=%b", v, bcd, en, ovf, to, eb, ee, eo); end
        end
    endtask

    task automatic test_random();
        int bc, dc; bit to, held, ov;
        logic [15:0] eb; logic eo; logic [3:0] ee;
        logic [9:0] v;
        for (int n = 0; n < 150; n++) begin
            v = 10'($urandom);
            ref_conv(int'(v), 3, eb, eo, ee);
            do_conv(1'b1, v, bc, dc, to, held, ov);
            checks++;
            if (to || bc != 10 || bcd3 !== eb[11:0] || en3 !== ee[2:0] || ovf3 !== eo)
                begin failures++; $display("FAIL rand3 v=%0d got bcd=%h en=%b ovf=%b busy=%0d exp bcd=%h en=%b ovf=%b busy=10", v, bcd3, en3, ovf3, bc, eb[11:0], ee[2:0], eo); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start3 = 1'b0; bin = '0; bin3 = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_single(10'd999);
        test_single(10'd0);
        test_single(10'd10);
        test_overflow3(10'd1023);
        test_overflow3(10'd500);
        test_overflow3(10'd999);
        test_overflow3(10'd1000);
        test_overflow3(10'd5);
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
